// File: rtl/alu_scheduler.sv
// Round-robin scheduler sharing one registered 8-bit ALU between two requesters.
// Optional macro ALU_SCHED_STATS_EN adds per-requester completed-op counters.
module alu_scheduler #(
    parameter int unsigned ALU_LATENCY = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req0_valid,
    output logic        req0_ready,
    input  logic [7:0]  req0_x,
    input  logic [7:0]  req0_y,
    input  logic [3:0]  req0_op,
    input  logic        req1_valid,
    output logic        req1_ready,
    input  logic [7:0]  req1_x,
    input  logic [7:0]  req1_y,
    input  logic [3:0]  req1_op,
    output logic        rsp0_valid,
    input  logic        rsp0_ready,
    output logic        rsp1_valid,
    input  logic        rsp1_ready,
    output logic [8:0]  rsp_z,
    output logic [7:0]  alu_x,
    output logic [7:0]  alu_y,
    output logic [3:0]  alu_control,
    input  logic [8:0]  alu_z,
    output logic        busy
`ifdef ALU_SCHED_STATS_EN
    ,
    output logic [15:0] op_cnt0,
    output logic [15:0] op_cnt1
`endif
);

    typedef enum logic [1:0] {StIdle, StWait, StResp} state_e;

    state_e      state_q, state_d;
    logic        owner_q, owner_d;
    logic        last_q, last_d;
    logic [2:0]  cnt_q, cnt_d;
    logic [7:0]  alu_x_q, alu_x_d;
    logic [7:0]  alu_y_q, alu_y_d;
    logic [3:0]  alu_ctrl_q, alu_ctrl_d;
    logic [8:0]  rsp_z_q, rsp_z_d;

    logic any_req;
    logic grant;
    logic rsp_done;

    // On a tie the requester that did not win last time is granted.
    assign any_req  = req0_valid | req1_valid;
    assign grant    = (req0_valid & req1_valid) ? ~last_q : req1_valid;
    assign rsp_done = (state_q == StResp) && (owner_q ? rsp1_ready : rsp0_ready);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= StIdle;
            owner_q    <= 1'b0;
            last_q     <= 1'b1;
            cnt_q      <= 3'd0;
            alu_x_q    <= 8'd0;
            alu_y_q    <= 8'd0;
            alu_ctrl_q <= 4'd0;
            rsp_z_q    <= 9'd0;
        end else begin
            state_q    <= state_d;
            owner_q    <= owner_d;
            last_q     <= last_d;
            cnt_q      <= cnt_d;
            alu_x_q    <= alu_x_d;
            alu_y_q    <= alu_y_d;
            alu_ctrl_q <= alu_ctrl_d;
            rsp_z_q    <= rsp_z_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        owner_d    = owner_q;
        last_d     = last_q;
        cnt_d      = cnt_q;
        alu_x_d    = alu_x_q;
        alu_y_d    = alu_y_q;
        alu_ctrl_d = alu_ctrl_q;
        rsp_z_d    = rsp_z_q;
        unique case (state_q)
            StIdle: begin
                if (any_req) begin
                    alu_x_d    = grant ? req1_x  : req0_x;
                    alu_y_d    = grant ? req1_y  : req0_y;
                    alu_ctrl_d = grant ? req1_op : req0_op;
                    owner_d    = grant;
                    last_d     = grant;
                    cnt_d      = 3'(ALU_LATENCY);
                    state_d    = StWait;
                end
            end
            StWait: begin
                if (cnt_q != 3'd0) begin
                    cnt_d = cnt_q - 3'd1;
                end else begin
                    rsp_z_d = alu_z;
                    state_d = StResp;
                end
            end
            StResp: begin
                if (rsp_done) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        req0_ready = (state_q == StIdle) && any_req && !grant;
        req1_ready = (state_q == StIdle) && any_req && grant;
        rsp0_valid = (state_q == StResp) && !owner_q;
        rsp1_valid = (state_q == StResp) && owner_q;
        busy       = (state_q != StIdle);
    end

    assign alu_x       = alu_x_q;
    assign alu_y       = alu_y_q;
    assign alu_control = alu_ctrl_q;
    assign rsp_z       = rsp_z_q;

`ifdef ALU_SCHED_STATS_EN
    logic [15:0] op_cnt0_q, op_cnt0_d;
    logic [15:0] op_cnt1_q, op_cnt1_d;

    always_comb begin
        op_cnt0_d = op_cnt0_q;
        op_cnt1_d = op_cnt1_q;
        if (rsp_done && !owner_q && (op_cnt0_q != 16'hFFFF)) begin
            op_cnt0_d = op_cnt0_q + 16'd1;
        end
        if (rsp_done && owner_q && (op_cnt1_q != 16'hFFFF)) begin
            op_cnt1_d = op_cnt1_q + 16'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_cnt0_q <= 16'd0;
            op_cnt1_q <= 16'd0;
        end else begin
            op_cnt0_q <= op_cnt0_d;
            op_cnt1_q <= op_cnt1_d;
        end
    end

    assign op_cnt0 = op_cnt0_q;
    assign op_cnt1 = op_cnt1_q;
`endif

endmodule

// File: tb/tb_alu_scheduler.sv
// Scoreboard bench for alu_scheduler with a registered stub ALU (z = x + y).
module tb_alu_scheduler;

    localparam int unsigned Lat = 1;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       req0_valid = 1'b0, req1_valid = 1'b0;
    logic       req0_ready, req1_ready;
    logic [7:0] req0_x = '0, req0_y = '0, req1_x = '0, req1_y = '0;
    logic [3:0] req0_op = '0, req1_op = '0;
    logic       rsp0_valid, rsp1_valid;
    logic       rsp0_ready = 1'b1, rsp1_ready = 1'b1;
    logic [8:0] rsp_z;
    logic [7:0] alu_x, alu_y;
    logic [3:0] alu_control;
    logic [8:0] alu_z = '0;
    logic       busy;
`ifdef ALU_SCHED_STATS_EN
    logic [15:0] op_cnt0, op_cnt1;
`endif

    alu_scheduler #(.ALU_LATENCY(Lat)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .req0_valid  (req0_valid),
        .req0_ready  (req0_ready),
        .req0_x      (req0_x),
        .req0_y      (req0_y),
        .req0_op     (req0_op),
        .req1_valid  (req1_valid),
        .req1_ready  (req1_ready),
        .req1_x      (req1_x),
        .req1_y      (req1_y),
        .req1_op     (req1_op),
        .rsp0_valid  (rsp0_valid),
        .rsp0_ready  (rsp0_ready),
        .rsp1_valid  (rsp1_valid),
        .rsp1_ready  (rsp1_ready),
        .rsp_z       (rsp_z),
        .alu_x       (alu_x),
        .alu_y       (alu_y),
        .alu_control (alu_control),
        .alu_z       (alu_z),
        .busy        (busy)
`ifdef ALU_SCHED_STATS_EN
        ,
        .op_cnt0     (op_cnt0),
        .op_cnt1     (op_cnt1)
`endif
    );

    always #5 clk = ~clk;

    always @(posedge clk) alu_z <= {1'b0, alu_x} + {1'b0, alu_y};

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int last_acc = 0;
    logic [8:0] exp0 = '0, exp1 = '0;
    logic [9:0] sb_q[$];
    logic       gnt_q[$];
    int         acc_q[$];
    logic       prev_v = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, req);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Acceptance monitor: the handshake completes at the next rising edge.
    always @(negedge clk) begin
        if (rst_n && (req0_ready || req1_ready)) begin
            sb_q.push_back(req1_ready ? {1'b1, exp1} : {1'b0, exp0});
            gnt_q.push_back(req1_ready);
            acc_q.push_back(cyc + 1);
            last_acc = cyc + 1;
        end
    end

    // Response monitor.
    always @(negedge clk) begin
        logic [9:0] e;
        if (rst_n) begin
            if (rsp0_valid && rsp1_valid) check("rsp_valid_exclusive", 32'd1, 32'd0);
            if ((rsp0_valid || rsp1_valid) && !prev_v)
                check("rsp_latency", 32'(cyc - last_acc), 32'(Lat + 1));
            if ((rsp0_valid && rsp0_ready) || (rsp1_valid && rsp1_ready)) begin
                if (sb_q.size() == 0) begin
                    check("rsp_unexpected", 32'd1, 32'd0);
                end else begin
                    e = sb_q.pop_front();
                    check("rsp_owner", {31'd0, rsp1_valid}, {31'd0, e[9]});
                    check("rsp_z", {23'd0, rsp_z}, {23'd0, e[8:0]});
                end
            end
        end
        prev_v = rsp0_valid || rsp1_valid;
    end

    task automatic wait_accept(input logic id);
        int n;
        for (n = 0; n < 50; n++) begin
            @(negedge clk);
            if (id ? req1_ready : req0_ready) break;
        end
        if (n == 50) check("accept_timeout", 32'd1, 32'd0);
    endtask

    task automatic wait_idle();
        int n;
        for (n = 0; n < 100; n++) begin
            @(negedge clk);
            if (!busy) break;
        end
        if (n == 100) check("idle_timeout", 32'd1, 32'd0);
    endtask

    task automatic run_op(input logic id, input logic [7:0] x, input logic [7:0] y,
                          input logic [8:0] z);
        @(posedge clk); #1;
        if (id) begin req1_x = x; req1_y = y; exp1 = z; req1_valid = 1'b1; end
        else    begin req0_x = x; req0_y = y; exp0 = z; req0_valid = 1'b0; req0_valid = 1'b1; end
        wait_accept(id);
        @(posedge clk); #1;
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        wait_idle();
    endtask

    task automatic pulse_reset();
        @(posedge clk); #1;
        rst_n = 1'b0;
        sb_q.delete();
        gnt_q.delete();
        acc_q.delete();
        @(posedge clk); #1;
        rst_n = 1'b1;
    endtask

    initial begin
        logic bad;
        int n;
        #2;
        check("reset_busy", {31'd0, busy}, 32'd0);
        check("reset_alu", {12'd0, alu_control, alu_x, alu_y}, 32'd0);
        check("reset_rsp", {21'd0, rsp_z, rsp0_valid, rsp1_valid}, 32'd0);
        #10 rst_n = 1'b1;

        // 1: single op on req0
        @(posedge clk); #1;
        req0_x = 8'hF0; req0_y = 8'h20; req0_op = 4'h0; exp0 = 9'h110; req0_valid = 1'b1;
        @(negedge clk);
        check("t1_ready_first_cycle", {31'd0, req0_ready}, 32'd1);
        @(posedge clk); #1;
        req0_valid = 1'b0;
        wait_idle();

        // 2: contention out of reset, grants alternate 0,1,0,1
        pulse_reset();
        req0_x = 8'h01; req0_y = 8'h02; exp0 = 9'h003;
        req1_x = 8'hFF; req1_y = 8'hFF; exp1 = 9'h1FE;
        req0_valid = 1'b1; req1_valid = 1'b1;
        for (n = 0; n < 60 && gnt_q.size() < 4; n++) @(posedge clk);
        #1;
        req0_valid = 1'b0; req1_valid = 1'b0;
        check("t2_grant_count", 32'(gnt_q.size()), 32'd4);
        if (gnt_q.size() == 4) begin
            for (int i = 0; i < 4; i++) begin
                check("t2_grant_order", {31'd0, gnt_q[i]}, 32'(i % 2));
                if (i > 0) check("t2_accept_spacing", 32'(acc_q[i] - acc_q[i-1]), 32'(Lat + 3));
            end
        end
        wait_idle();

        // 3: backpressure on rsp1
        rsp1_ready = 1'b0;
        @(posedge clk); #1;
        req1_x = 8'h10; req1_y = 8'h05; exp1 = 9'h015; req1_valid = 1'b1;
        wait_accept(1'b1);
        @(posedge clk); #1;
        req1_valid = 1'b0;
        for (n = 0; n < 20; n++) begin
            @(negedge clk);
            if (rsp1_valid) break;
        end
        check("t3_rsp1_rise", {31'd0, rsp1_valid}, 32'd1);
        @(posedge clk); #1;
        req0_x = 8'h07; req0_y = 8'h08; exp0 = 9'h00F; req0_valid = 1'b1;
        bad = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            bad |= (rsp_z != 9'h015) | !rsp1_valid | rsp0_valid | !busy | req0_ready | req1_ready;
        end
        check("t3_held_stable", {31'd0, bad}, 32'd0);
        @(posedge clk); #1;
        rsp1_ready = 1'b1;
        @(negedge clk);
        check("t3_still_resp", {31'd0, req0_ready}, 32'd0);
        @(negedge clk);
        check("t3_idle_after_take", {30'd0, busy, req0_ready}, 32'd1);
        @(posedge clk); #1;
        req0_valid = 1'b0;
        wait_idle();

        // 4: reset one cycle after an accept
        @(posedge clk); #1;
        req0_x = 8'hAA; req0_y = 8'h01; exp0 = 9'h0AB; req0_valid = 1'b1;
        wait_accept(1'b0);
        @(posedge clk); #1;
        req0_valid = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        check("t4_busy_async", {31'd0, busy}, 32'd0);
        check("t4_alu_async", {12'd0, alu_control, alu_x, alu_y}, 32'd0);
        check("t4_rsp_async", {21'd0, rsp_z, rsp0_valid, rsp1_valid}, 32'd0);
        sb_q.delete(); gnt_q.delete(); acc_q.delete();
        @(posedge clk); #1;
        rst_n = 1'b1;
        bad = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            bad |= busy | rsp0_valid | rsp1_valid;
        end
        check("t4_no_rsp_after_reset", {31'd0, bad}, 32'd0);
        @(posedge clk); #1;
        req0_x = 8'h03; req0_y = 8'h04; exp0 = 9'h007;
        req1_x = 8'h09; req1_y = 8'h09; exp1 = 9'h012;
        req0_valid = 1'b1; req1_valid = 1'b1;
        for (n = 0; n < 20 && gnt_q.size() < 1; n++) @(posedge clk);
        #1;
        req0_valid = 1'b0; req1_valid = 1'b0;
        check("t4_first_tie", (gnt_q.size() > 0) ? {31'd0, gnt_q[0]} : 32'hDEAD, 32'd0);
        wait_idle();

        // 5: op passthrough on req1
        rsp1_ready = 1'b0;
        @(posedge clk); #1;
        req1_x = 8'h55; req1_y = 8'hAA; req1_op = 4'hA; exp1 = 9'h0FF; req1_valid = 1'b1;
        wait_accept(1'b1);
        @(posedge clk); #1;
        req1_valid = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            check("t5_alu_hold", {12'd0, alu_control, alu_x, alu_y}, 32'h000A55AA);
        end
        @(posedge clk); #1;
        rsp1_ready = 1'b1;
        @(negedge clk);
        check("t5_alu_at_take", {12'd0, alu_control, alu_x, alu_y}, 32'h000A55AA);
        wait_idle();

`ifdef ALU_SCHED_STATS_EN
        // 6: completed-op counters and saturation
        pulse_reset();
        run_op(1'b0, 8'h01, 8'h01, 9'h002);
        run_op(1'b1, 8'h02, 8'h02, 9'h004);
        run_op(1'b0, 8'h03, 8'h03, 9'h006);
        run_op(1'b1, 8'h04, 8'h04, 9'h008);
        run_op(1'b0, 8'h05, 8'h05, 9'h00A);
        check("t6_op_cnt0", {16'd0, op_cnt0}, 32'd3);
        check("t6_op_cnt1", {16'd0, op_cnt1}, 32'd2);
        dut.op_cnt0_q = 16'hFFFE;
        run_op(1'b0, 8'h10, 8'h10, 9'h020);
        run_op(1'b0, 8'h11, 8'h11, 9'h022);
        check("t6_op_cnt0_sat", {16'd0, op_cnt0}, 32'h0000FFFF);
`endif

        repeat (3) @(negedge clk);
        check("sb_drained", 32'(sb_q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
